// File: rtl/xctcmsg_pkg.sv
// Shared types for the writeback path: payload struct and requester indices.
package xctcmsg_pkg;

    localparam int WB_REG_W   = 5;
    localparam int WB_VALUE_W = 32;

    typedef enum logic {
        REQ_POSTOFFICE = 1'b0,
        REQ_RECEIVE    = 1'b1
    } req_idx_e;

    typedef struct packed {
        logic [WB_REG_W-1:0]   register;
        logic [WB_VALUE_W-1:0] value;
        logic                  passthrough;
    } writeback_arbiter_data_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: one-hot grant, bit index equals req_idx_e.
// Latency: combinational.
// Backpressure: no grant at all while enable is low.
module rr_arbiter2
    import xctcmsg_pkg::*;
(
    input  logic       enable,
    input  logic [1:0] req,
    input  req_idx_e   last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                // On contention the side that did not win last time goes first.
                grant = (last_grant == REQ_POSTOFFICE) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges postoffice and receive writebacks into one registered output stage; optional grant counters under XCTCMSG_WB_ARB_STATS_EN.
// Latency: one cycle from acknowledge to core valid.
// Backpressure: acknowledges only when the stage is empty or draining this cycle, and never during flush.
module writeback_arbiter
    import xctcmsg_pkg::*;
#(
    parameter int STAT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    postoffice_writeback_arbiter_valid,
    output logic                    writeback_arbiter_postoffice_acknowledge,
    input  writeback_arbiter_data_t postoffice_writeback_arbiter_data,
    input  logic                    receive_writeback_arbiter_valid,
    output logic                    writeback_arbiter_receive_acknowledge,
    input  writeback_arbiter_data_t receive_writeback_arbiter_data,
    output logic                    writeback_arbiter_core_valid,
    input  logic                    core_writeback_arbiter_ready,
    output writeback_arbiter_data_t writeback_arbiter_core_data
`ifdef XCTCMSG_WB_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   writeback_arbiter_postoffice_grants,
    output logic [STAT_WIDTH-1:0]   writeback_arbiter_receive_grants
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e     state;
    req_idx_e   last_grant;
    logic       allocatable;
    logic       grant_en;
    logic [1:0] grant;
    logic       grant_any;

    assign allocatable = (state == ST_EMPTY) || core_writeback_arbiter_ready;
    // rst_n gates the enable so acknowledges are low throughout reset, not just after the next edge.
    assign grant_en    = rst_n && allocatable && !flush;

    rr_arbiter2 u_rr_arbiter2 (
        .enable     (grant_en),
        .req        ({receive_writeback_arbiter_valid, postoffice_writeback_arbiter_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign grant_any = |grant;
    assign writeback_arbiter_postoffice_acknowledge = grant[REQ_POSTOFFICE];
    assign writeback_arbiter_receive_acknowledge    = grant[REQ_RECEIVE];
    assign writeback_arbiter_core_valid             = (state == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            last_grant <= REQ_POSTOFFICE;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (grant_any) begin
            state      <= ST_FULL;
            last_grant <= grant[REQ_RECEIVE] ? REQ_RECEIVE : REQ_POSTOFFICE;
        end else if (state == ST_FULL && core_writeback_arbiter_ready) begin
            state <= ST_EMPTY;
        end
    end

    // Payload needs no reset: it is only observed while the stage is FULL.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            writeback_arbiter_core_data <= grant[REQ_RECEIVE] ? receive_writeback_arbiter_data
                                                              : postoffice_writeback_arbiter_data;
        end
    end

`ifdef XCTCMSG_WB_ARB_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeback_arbiter_postoffice_grants <= '0;
            writeback_arbiter_receive_grants    <= '0;
        end else begin
            if (grant[REQ_POSTOFFICE] && writeback_arbiter_postoffice_grants != STAT_MAX) begin
                writeback_arbiter_postoffice_grants <= writeback_arbiter_postoffice_grants + 1'b1;
            end
            if (grant[REQ_RECEIVE] && writeback_arbiter_receive_grants != STAT_MAX) begin
                writeback_arbiter_receive_grants <= writeback_arbiter_receive_grants + 1'b1;
            end
        end
    end
`else
    if (STAT_WIDTH > 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed plus random stimulus against a transaction-level model of the writeback stage.
module tb_writeback_arbiter;
    import xctcmsg_pkg::*;

`ifdef XCTCMSG_WB_ARB_STATS_EN
    localparam int SW = 2;
`else
    localparam int SW = 32;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, po_vld, rx_vld, ready;
    logic po_ack, rx_ack, core_vld;
    writeback_arbiter_data_t po_dat, rx_dat, core_dat;
`ifdef XCTCMSG_WB_ARB_STATS_EN
    logic [SW-1:0] po_cnt, rx_cnt;
`endif

    writeback_arbiter #(.STAT_WIDTH(SW)) dut (
        .clk                                      (clk),
        .rst_n                                    (rst_n),
        .flush                                    (flush),
        .postoffice_writeback_arbiter_valid       (po_vld),
        .writeback_arbiter_postoffice_acknowledge (po_ack),
        .postoffice_writeback_arbiter_data        (po_dat),
        .receive_writeback_arbiter_valid          (rx_vld),
        .writeback_arbiter_receive_acknowledge    (rx_ack),
        .receive_writeback_arbiter_data           (rx_dat),
        .writeback_arbiter_core_valid             (core_vld),
        .core_writeback_arbiter_ready             (ready),
        .writeback_arbiter_core_data              (core_dat)
`ifdef XCTCMSG_WB_ARB_STATS_EN
        ,
        .writeback_arbiter_postoffice_grants      (po_cnt),
        .writeback_arbiter_receive_grants         (rx_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Model: an optional held item, who won last, and grant tallies.
    logic                    m_full;
    writeback_arbiter_data_t m_data;
    int                      m_last;   // 0 = postoffice, 1 = receive
    longint                  m_po_cnt, m_rx_cnt;
    longint                  m_max;
    logic                    obs_po, obs_rx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full   = 1'b0;
        m_last   = 0;
        m_po_cnt = 0;
        m_rx_cnt = 0;
    endtask

    function automatic writeback_arbiter_data_t rand_dat();
        writeback_arbiter_data_t d;
        d.register    = 5'($urandom);
        d.value       = $urandom;
        d.passthrough = 1'($urandom);
        return d;
    endfunction

    // Checks one cycle at the negedge, then advances the model across the posedge.
    task automatic step();
        logic e_po, e_rx, can_take;
        @(negedge clk);
        e_po = 1'b0;
        e_rx = 1'b0;
        can_take = rst_n && !flush && (!m_full || ready);
        if (can_take) begin
            if (po_vld && rx_vld) begin
                if (m_last == 0) e_rx = 1'b1;
                else             e_po = 1'b1;
            end else begin
                e_po = po_vld;
                e_rx = rx_vld;
            end
        end
        obs_po = po_ack;
        obs_rx = rx_ack;
        check("po_ack", po_ack, e_po);
        check("rx_ack", rx_ack, e_rx);
        check("core_vld", core_vld, m_full);
        if (m_full) check("core_dat", core_dat, m_data);
`ifdef XCTCMSG_WB_ARB_STATS_EN
        check("po_cnt", po_cnt, m_po_cnt);
        check("rx_cnt", rx_cnt, m_rx_cnt);
`endif
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_full = 1'b0;
        end else if (e_po || e_rx) begin
            m_full = 1'b1;
            m_data = e_po ? po_dat : rx_dat;
            m_last = e_po ? 0 : 1;
            if (e_po && m_po_cnt < m_max) m_po_cnt++;
            if (e_rx && m_rx_cnt < m_max) m_rx_cnt++;
        end else if (m_full && ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_max  = (SW >= 63) ? 64'h7fff_ffff_ffff_ffff : ((64'sd1 <<< SW) - 1);
        rst_n  = 1'b0;
        flush  = 1'b0;
        ready  = 1'b1;
        po_vld = 1'b1;
        rx_vld = 1'b1;
        po_dat = rand_dat();
        rx_dat = rand_dat();
        model_reset();
        #2;
        // Reset: valids high but nothing may be acknowledged.
        step();
        step();
        rst_n  = 1'b1;
        po_vld = 1'b0;
        rx_vld = 1'b0;
        step();

        // Single postoffice writeback, register 5 value 1.
        po_vld = 1'b1;
        po_dat = '{register: 5'd5, value: 32'd1, passthrough: 1'b0};
        step();
        check("single_ack", obs_po, 1'b1);
        po_vld = 1'b0;
        step();
        check("single_reg", core_dat.register, 5'd5);
        check("single_val", core_dat.value, 32'd1);

        // Continuous contention, ready high: receive first, then alternate, no bubble.
        po_vld = 1'b1;
        rx_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("alt_rx", obs_rx, (i % 2 == 0));
            check("alt_po", obs_po, (i % 2 == 1));
            if (obs_po) po_dat = rand_dat();
            if (obs_rx) rx_dat = rand_dat();
            if (i > 0) check("no_bubble", core_vld, 1'b1);
        end

        // Stall: ready low for three cycles, then release.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ready = 1'b1;
        step();
        check("stall_release", obs_po ^ obs_rx, 1'b1);
        if (obs_po) po_dat = rand_dat();
        if (obs_rx) rx_dat = rand_dat();

        // Flush while full with both requesting.
        flush = 1'b1;
        step();
        check("flush_no_ack", obs_po | obs_rx, 1'b0);
        flush = 1'b0;
        check("flush_empty", core_vld, 1'b0);
        step();
        if (obs_po) po_dat = rand_dat();
        if (obs_rx) rx_dat = rand_dat();
        step();
        if (obs_po) po_dat = rand_dat();
        if (obs_rx) rx_dat = rand_dat();

        // Asynchronous reset mid-cycle while full.
        check("pre_areset_full", core_vld, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_vld", core_vld, 1'b0);
        check("areset_po_ack", po_ack, 1'b0);
        check("areset_rx_ack", rx_ack, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("areset_first_rx", obs_rx, 1'b1);
        rx_vld = 1'b0;
        po_vld = 1'b0;
        step();
        step();

`ifdef XCTCMSG_WB_ARB_STATS_EN
        // Saturation: five postoffice grants into a 2-bit counter.
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        po_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            po_dat = rand_dat();
        end
        po_vld = 1'b0;
        step();
        check("sat_po_cnt", po_cnt, 2'd3);
        check("sat_rx_cnt", rx_cnt, 2'd0);
`endif

        // Random traffic obeying the hold-until-acknowledged rule.
        for (int i = 0; i < 400; i++) begin
            if (!po_vld || obs_po) begin
                po_vld = 1'($urandom_range(0, 1));
                po_dat = rand_dat();
            end
            if (!rx_vld || obs_rx) begin
                rx_vld = 1'($urandom_range(0, 1));
                rx_dat = rand_dat();
            end
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter STAT_WIDTH, default 32: width of each grant statistics counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port flush, input, 1, synchronous pipeline flush.
REQ-005 SHALL have port postoffice_writeback_arbiter_valid, input, 1, postoffice request pending.
REQ-006 SHALL have port writeback_arbiter_postoffice_acknowledge, output, 1, one-cycle pulse: postoffice request consumed.
REQ-007 SHALL have port postoffice_writeback_arbiter_data, input, writeback_arbiter_data_t, postoffice register, value and passthrough.
REQ-008 SHALL have port receive_writeback_arbiter_valid, input, 1, receive-unit request pending.
REQ-009 SHALL have port writeback_arbiter_receive_acknowledge, output, 1, one-cycle pulse: receive request consumed.
REQ-010 SHALL have port receive_writeback_arbiter_data, input, writeback_arbiter_data_t, receive-unit writeback payload.
REQ-011 SHALL have port writeback_arbiter_core_valid, output, 1, output stage holds a writeback.
REQ-012 SHALL have port core_writeback_arbiter_ready, input, 1, core writeback port accepts this cycle.
REQ-013 SHALL have port writeback_arbiter_core_data, output, writeback_arbiter_data_t, payload of the output stage.

Function
REQ-014 SHALL keep a one-entry output stage with state EMPTY or FULL; writeback_arbiter_core_valid is high exactly in FULL.
REQ-015 SHALL treat the stage as allocatable when EMPTY, or when FULL and core_writeback_arbiter_ready is high.
REQ-016 SHALL grant at most one requester per cycle, and only when allocatable and flush is low.
REQ-017 SHALL pulse the granted requester's acknowledge in the grant cycle, combinationally, and load its data into the stage on the next edge.
REQ-018 SHALL hold the acknowledge of a non-granted requester low; requesters hold valid and data stable until acknowledged.
REQ-019 SHALL give latency of exactly one cycle: grant at edge N, core_valid with that data from N+1.
REQ-020 SHALL arbitrate round-robin: a 1-bit last_grant pointer updates on every grant, and on contention the requester not granted last wins.
REQ-021 SHALL grant a sole requester regardless of the pointer.
REQ-022 SHALL, on FULL with ready high and a grant, replace the stage contents and stay FULL (no bubble).
REQ-023 SHALL, on FULL with ready high and no grant, go EMPTY.
REQ-024 SHALL, on FULL with ready low, hold data and valid stable and issue no acknowledge.
REQ-025 SHALL, on flush, go EMPTY on the next edge, suppress all acknowledges that cycle and keep last_grant.

Reset
REQ-026 SHALL, while rst_n is low: stage EMPTY, core_valid 0, both acknowledges 0, last_grant set so that receive has priority on first contention, counters 0.
REQ-027 SHALL clear state on rst_n assertion regardless of clock, including mid-transfer; data register contents are don't-care.

Configuration
REQ-028 SHALL compile STAT_WIDTH-bit per-requester grant counters, saturating at all-ones and not cleared by flush, under macro XCTCMSG_WB_ARB_STATS_EN, exposed as outputs writeback_arbiter_postoffice_grants and writeback_arbiter_receive_grants.
REQ-029 SHALL, without XCTCMSG_WB_ARB_STATS_EN, omit the counters and their ports entirely, with identical arbitration behaviour.

Structure
REQ-030 SHALL use writeback_arbiter_data_t and a requester-index enum (REQ_POSTOFFICE=0, REQ_RECEIVE=1) from xctcmsg_pkg.
REQ-031 SHALL put the grant logic (two requests plus pointer in, one-hot grant out) in sub-module rr_arbiter2; the stage and counters stay in the top module.

Verification
REQ-032 Reset, then postoffice valid with register=5, value=1 -> postoffice ack pulse in cycle 0; core_valid with register=5, value=1 in cycle 1.
REQ-033 Both valid continuously, core ready=1 -> acknowledges alternate receive, postoffice, receive, ...; core_valid stays high with no bubble.
REQ-034 Stage FULL, core ready=0 for 3 cycles, both requesting -> no acks and data stable; ready=1 -> one ack that cycle.
REQ-035 Stage FULL, flush=1 with both requesting -> no acks; core_valid=0 next cycle; both still pending afterwards and granted per the retained pointer.
REQ-036 rst_n dropped asynchronously mid-cycle while FULL -> core_valid and acks 0 immediately; first contention after reset grants receive.
REQ-037 With XCTCMSG_WB_ARB_STATS_EN and STAT_WIDTH=2: 5 postoffice grants -> counter reads 3 (saturated), receive counter 0.
